hazard_stall_controller: RTL and testbench

- Producer of pipeline-control signals for the 5-stage pipeline: load-use stalls, branch flushes, and whole-pipeline freezes while data memory is not ready.
- Forwarding resolves ALU operand hazards; this block handles the hazards forwarding cannot cover.
- Sits beside the ID/EX stages and drives the PC and the IF/ID, ID/EX and EX/MEM pipeline-register enables and flushes.
- Keeps saturating event counters and a sticky memory-timeout flag for debug.

---
 rtl/hazard_stall_controller_if.sv | 38 +++
 rtl/hazard_stall_controller.sv | 134 +++++++++++++
 tb/tb_hazard_stall_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-control bus between the 5-stage pipeline and the hazard/stall controller.
// master = pipeline side (drives hazard sources); slave = controller side.
interface hazard_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_Rs;
  logic [4:0]       ID_Rt;
  logic             ID_UsesRt;
  logic             EX_MemRead;
  logic [4:0]       EX_RegDst;
  logic             EX_BranchTaken;
  logic             MEM_Req;
  logic             MEM_Ready;
  logic             PC_Write;
  logic             IFID_Write;
  logic             IDEX_Bubble;
  logic             IFID_Flush;
  logic             IDEX_Flush;
  logic             Freeze;
  logic             MemTimeout;
  logic [CNT_W-1:0] StallCount;
  logic [CNT_W-1:0] FlushCount;
  logic [CNT_W-1:0] WaitCount;

  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegDst, EX_BranchTaken,
           MEM_Req, MEM_Ready,
    input  PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze,
           MemTimeout, StallCount, FlushCount, WaitCount
  );

  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, EX_MemRead, EX_RegDst, EX_BranchTaken,
           MEM_Req, MEM_Ready,
    output PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze,
           MemTimeout, StallCount, FlushCount, WaitCount
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard/stall controller: load-use stalls, taken-branch flushes and whole-pipeline
// freezes while data memory is busy, with a bounded memory wait, saturating debug
// counters and a sticky timeout flag. Control outputs are combinational.
module hazard_stall_controller #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_stall_controller_if.slave  bus
);

  typedef enum logic {S_RUN, S_WAIT} state_e;

  localparam int              WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] wait_evt_q, wait_evt_d;

  logic memstall, loaduse;
  logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, freeze;

  // Hazard detection and prioritised pipeline-control outputs
  always_comb begin
    memstall    = 1'b0;
    loaduse     = 1'b0;
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    freeze      = 1'b0;

    // In WAIT the last allowed cycle releases the freeze even if memory is still busy
    if (state_q == S_RUN)
      memstall = bus.MEM_Req && !bus.MEM_Ready;
    else
      memstall = !bus.MEM_Ready && (wait_cnt_q != WC_LAST);

    // A load into $0 never produces a hazard; Rt only counts when actually read
    loaduse = bus.EX_MemRead && (bus.EX_RegDst != 5'd0) &&
              ((bus.EX_RegDst == bus.ID_Rs) ||
               (bus.ID_UsesRt && (bus.EX_RegDst == bus.ID_Rt)));

    if (!rst_n) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (memstall) begin
      // Branch and load-use are simply re-evaluated once the freeze lifts
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (bus.EX_BranchTaken) begin
      // The dependent instruction is squashed, so any load-use is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loaduse) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Memory-wait FSM, sticky timeout flag and saturating event counters
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = timeout_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_evt_d  = wait_evt_q;

    case (state_q)
      S_RUN: begin
        if (bus.MEM_Req && !bus.MEM_Ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (bus.MEM_Ready) begin
          state_d = S_RUN;
        end else if (wait_cnt_q == WC_LAST) begin
          // Abandon the access; a still-pending request re-enters WAIT from RUN
          state_d   = S_RUN;
          timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      default: state_d = S_RUN;
    endcase

    if (idex_bubble && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_flush  && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (freeze      && (wait_evt_q  != '1)) wait_evt_d  = wait_evt_q  + CNT_W'(1);
  end

  // State registers; reset drops any pending wait immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      wait_evt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      wait_evt_q  <= wait_evt_d;
    end
  end

  assign bus.PC_Write    = pc_write;
  assign bus.IFID_Write  = ifid_write;
  assign bus.IDEX_Bubble = idex_bubble;
  assign bus.IFID_Flush  = ifid_flush;
  assign bus.IDEX_Flush  = idex_flush;
  assign bus.Freeze      = freeze;
  assign bus.MemTimeout  = timeout_q;
  assign bus.StallCount  = stall_cnt_q;
  assign bus.FlushCount  = flush_cnt_q;
  assign bus.WaitCount   = wait_evt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: combinational vector table plus multi-cycle
// sequences. Two instances share stimulus: A (TIMEOUT=4, CNT_W=16) and
// B (TIMEOUT=4, CNT_W=2) for counter saturation.
module tb_hazard_stall_controller;

  logic clk;
  logic rst_n;

  hazard_stall_controller_if #(.CNT_W(16)) ifa ();
  hazard_stall_controller_if #(.CNT_W(2))  ifb ();

  hazard_stall_controller #(.TIMEOUT(4), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  hazard_stall_controller #(.TIMEOUT(4), .CNT_W(2))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  assign ifb.ID_Rs          = ifa.ID_Rs;
  assign ifb.ID_Rt          = ifa.ID_Rt;
  assign ifb.ID_UsesRt      = ifa.ID_UsesRt;
  assign ifb.EX_MemRead     = ifa.EX_MemRead;
  assign ifb.EX_RegDst      = ifa.EX_RegDst;
  assign ifb.EX_BranchTaken = ifa.EX_BranchTaken;
  assign ifb.MEM_Req        = ifa.MEM_Req;
  assign ifb.MEM_Ready      = ifa.MEM_Ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PC_Write, IFID_Write, IDEX_Bubble, IFID_Flush, IDEX_Flush, Freeze}
  logic [5:0] ctl_a;
  assign ctl_a = {ifa.PC_Write, ifa.IFID_Write, ifa.IDEX_Bubble,
                  ifa.IFID_Flush, ifa.IDEX_Flush, ifa.Freeze};

  localparam logic [5:0] C_RUN   = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b001000;
  localparam logic [5:0] C_FLUSH = 6'b110110;
  localparam logic [5:0] C_FRZ   = 6'b000001;
  localparam logic [5:0] C_RST   = 6'b000000;

  typedef struct {
    string      nm;
    logic [4:0] rs, rt;
    logic       ut, mr;
    logic [4:0] rd;
    logic       br, req, rdy;
    logic [5:0] exp;
  } vec_t;

  typedef struct {
    string      nm;
    logic [5:0] ctl;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(logic [4:0] rs, logic [4:0] rt, logic ut, logic mr,
                       logic [4:0] rd, logic br, logic req, logic rdy);
    ifa.ID_Rs          = rs;
    ifa.ID_Rt          = rt;
    ifa.ID_UsesRt      = ut;
    ifa.EX_MemRead     = mr;
    ifa.EX_RegDst      = rd;
    ifa.EX_BranchTaken = br;
    ifa.MEM_Req        = req;
    ifa.MEM_Ready      = rdy;
  endtask

  task automatic idle();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      checks++;
      if (ctl_a !== e.ctl) begin
        errors++;
        $display("FAIL %s: ctl got %b expected %b", e.nm, ctl_a, e.ctl);
      end
    end
  endtask

  // Called at posedge+1 with inputs driven: compare, then advance one edge
  task automatic step(string nm, logic [5:0] e);
    sb.push_back('{nm, e});
    #2;
    sb_check();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{"idle",            5'd1, 5'd2, 1'b1, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[1]  = '{"lu_rs",           5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_STALL};
    vecs[2]  = '{"lu_rt",           5'd4, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_STALL};
    vecs[3]  = '{"rt_unused",       5'd4, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[4]  = '{"r0_rs",           5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[5]  = '{"r0_rt",           5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[6]  = '{"no_load",         5'd6, 5'd6, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b0, C_RUN};
    vecs[7]  = '{"branch",          5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, C_FLUSH};
    vecs[8]  = '{"branch_lu",       5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_FLUSH};
    vecs[9]  = '{"mem_busy",        5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0, C_FRZ};
    vecs[10] = '{"mem_busy_br_lu",  5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, C_FRZ};
    vecs[11] = '{"mem_ready_lu",    5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, C_STALL};

    // Reset state, including a branch presented while in reset
    rst_n = 1'b0;
    idle();
    #1;
    sb.push_back('{"reset_ctl", C_RST});
    sb_check();
    check("reset_timeout", int'(ifa.MemTimeout), 0);
    check("reset_stallcnt", int'(ifa.StallCount), 0);
    check("reset_waitcnt", int'(ifa.WaitCount), 0);
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    #1;
    sb.push_back('{"reset_ctl_busy", C_RST});
    sb_check();
    do_reset();

    // Combinational table from RUN; a reset pulse before each edge keeps state in RUN
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].rs, vecs[i].rt, vecs[i].ut, vecs[i].mr, vecs[i].rd,
            vecs[i].br, vecs[i].req, vecs[i].rdy);
      sb.push_back('{vecs[i].nm, vecs[i].exp});
      #2;
      sb_check();
      rst_n = 1'b0;
      idle();
      #1;
      rst_n = 1'b1;
    end

    // Load-use on Rs: one bubble cycle, then the pipeline advances
    do_reset();
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_seq_stall", C_STALL);
    drive(5'd5, 5'd2, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0);
    step("lu_seq_resume", C_RUN);
    check("lu_stallcnt", int'(ifa.StallCount), 1);

    // Rt gating and $0
    do_reset();
    drive(5'd3, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    step("rt_gate_seq", C_RUN);
    drive(5'd0, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    step("r0_seq", C_RUN);
    check("gate_stallcnt", int'(ifa.StallCount), 0);

    // Branch together with load-use
    do_reset();
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    step("br_lu_seq", C_FLUSH);
    check("br_lu_flushcnt", int'(ifa.FlushCount), 1);
    check("br_lu_stallcnt", int'(ifa.StallCount), 0);

    // Memory wait of 3 cycles with a branch held during the freeze
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("memwait_frz", C_FRZ);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b1);
    step("memwait_ready", C_FLUSH);
    idle();
    check("memwait_waitcnt", int'(ifa.WaitCount), 3);
    check("memwait_flushcnt", int'(ifa.FlushCount), 1);
    check("memwait_timeout", int'(ifa.MemTimeout), 0);

    // Timeout: 4 frozen cycles, one released cycle, then WAIT re-entered
    do_reset();
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("to_frz", C_FRZ);
    check("to_flag_before", int'(ifa.MemTimeout), 0);
    step("to_release", C_RUN);
    check("to_flag_set", int'(ifa.MemTimeout), 1);
    step("to_reenter", C_FRZ);
    step("to_rewait", C_FRZ);
    check("to_flag_sticky", int'(ifa.MemTimeout), 1);
    check("to_waitcnt_a", int'(ifa.WaitCount), 6);
    check("to_waitcnt_b_sat", int'(ifb.WaitCount), 3);

    // Reset asserted mid-WAIT takes effect without a clock edge
    rst_n = 1'b0;
    #1;
    sb.push_back('{"midwait_rst_ctl", C_RST});
    sb_check();
    check("midwait_rst_waitcnt", int'(ifa.WaitCount), 0);
    check("midwait_rst_timeout", int'(ifa.MemTimeout), 0);
    check("midwait_rst_b_waitcnt", int'(ifb.WaitCount), 0);
    drive(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("midwait_after_rst", C_RUN);

    // Counter saturation: 5 stall cycles
    do_reset();
    drive(5'd5, 5'd2, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("sat_stall", C_STALL);
    check("sat_stallcnt_a", int'(ifa.StallCount), 5);
    check("sat_stallcnt_b", int'(ifb.StallCount), 3);
    idle();

    if (sb.size() != 0) check("scoreboard_leftover", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
